// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Overrun and framing errors are reported through sticky flags.
module uart_rx_fifo #(
  parameter int CLK_HZ          = 140000000,
  parameter int SCLK_HZ         = 115200,
  parameter int FIFO_DEPTH_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     uart_rxd,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [FIFO_DEPTH_BITS:0] count,
  output logic                     overrun,
  output logic                     frame_err,
  input  logic                     err_clr
);

  localparam int DIV   = CLK_HZ / SCLK_HZ;
  localparam int HALF  = DIV / 2;
  localparam int CW    = $clog2(DIV);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT = (FIFO_DEPTH_BITS + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                       rx_meta;
  logic                       rxs;
  logic [2:0]                 state;
  logic [CW-1:0]              cnt;
  logic [2:0]                 idx;
  logic [7:0]                 shreg;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic                       stop_tick;
  logic                       full;
  logic                       pop;
  logic                       push;
  logic                       drop;
  logic                       ferr_set;

  // A pop in the stop-sample cycle frees a slot, so a full FIFO still accepts the byte.
  assign stop_tick = (state == S_STOP) && (cnt == '0);
  assign full      = (count == FULL_CNT);
  assign pop       = rd_en && rd_valid;
  assign push      = stop_tick && rxs && (!full || pop);
  assign drop      = stop_tick && rxs && full && !pop;
  assign ferr_set  = stop_tick && !rxs;
  assign rd_valid  = (count != '0);
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            cnt   <= HALF_M1;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rxs) begin
            state <= S_IDLE;
          end else begin
            cnt   <= DIV_M1;
            idx   <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shreg[idx] <= rxs;
            cnt        <= DIV_M1;
            if (idx == 3'd7) state <= S_STOP;
            else             idx   <= idx + 3'd1;
          end
        end
        S_STOP: begin
          if (cnt != '0) cnt   <= cnt - CW'(1);
          else           state <= rxs ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= drop     || (overrun   && !err_clr);
      frame_err <= ferr_set || (frame_err && !err_clr);
    end
  end

endmodule
